// File: rtl/logic_depth_pkg.sv
// logic_depth_pkg: FSM states, default widths and saturating helpers shared by logic_depth_profiler.
package logic_depth_pkg;
    localparam int DEF_N_CH = 8;
    localparam int DEF_W = 8;
    localparam int DEF_WIN = 16;
    localparam int DEF_FF_W = 16;
    localparam int CALC_W = 32;

    typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

    function automatic logic [CALC_W-1:0] sat_sub(input logic [CALC_W-1:0] a, input logic [CALC_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c += 7'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/ldp_chan_depth.sv
// ldp_chan_depth: per-channel saturating depth estimate; threshold compare built only with LDP_VIOL_EN.
module ldp_chan_depth
    import logic_depth_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] gate_count,
    input  logic [W-1:0] path_length,
    input  logic [W-1:0] num_ff,
    input  logic [W-1:0] depth_limit,
    input  logic         fan_in,
    input  logic         fan_out,
    input  logic         en,
    output logic [W-1:0] depth,
    output logic         viol
);
    localparam int SW = W + 2;

    logic [SW-1:0]     sum;
    logic [CALC_W-1:0] diff;

    assign sum = SW'(gate_count) + SW'(path_length) + SW'(fan_in) + SW'(fan_out);
    assign diff = sat_sub(CALC_W'(sum), CALC_W'(num_ff));
    assign depth = (|diff[CALC_W-1:W]) ? '1 : diff[W-1:0];

`ifdef LDP_VIOL_EN
    assign viol = en && (depth > depth_limit);
`else
    logic unused_cfg;
    assign unused_cfg = ^{en, depth_limit};
    assign viol = 1'b0;
`endif
endmodule

// File: rtl/logic_depth_profiler.sv
// logic_depth_profiler: windowed peak-depth / flip-flop-total profiler with held result handshake.
// Define LDP_VIOL_EN to build the sticky per-channel depth_limit violation mask.
module logic_depth_profiler
    import logic_depth_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int W    = DEF_W,
    parameter int WIN  = DEF_WIN,
    parameter int FF_W = DEF_FF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [N_CH-1:0]         fan_in,
    input  logic [N_CH-1:0]         fan_out,
    input  logic [W-1:0]            gate_count,
    input  logic [W-1:0]            path_length,
    input  logic [W-1:0]            num_ff,
    input  logic [W-1:0]            depth_limit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            max_depth,
    output logic [$clog2(N_CH)-1:0] max_ch,
    output logic [FF_W-1:0]         ff_total,
    output logic [N_CH-1:0]         viol_mask
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(WIN + 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             accept, last, clear;
    logic [W-1:0]     depth_c [N_CH];
    logic [N_CH-1:0]  viol_c;
    logic             s1_valid;
    logic [W-1:0]     s1_depth [N_CH];
    logic [N_CH-1:0]  s1_mask;
    logic [W-1:0]     s1_ff;
    logic [W-1:0]     max_nx;
    logic [CH_W-1:0]  ch_nx;
    logic [63:0]      ff_sum;
    logic [FF_W-1:0]  ff_nx;

    assign in_ready = (state == ACCUM);
    assign out_valid = (state == REPORT);
    assign accept = in_valid && in_ready;
    assign last = (cnt == CNT_W'(WIN - 1));
    assign clear = out_valid && out_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ldp_chan_depth #(.W(W)) u_chan (
            .gate_count (gate_count),
            .path_length(path_length),
            .num_ff     (num_ff),
            .depth_limit(depth_limit),
            .fan_in     (fan_in[i]),
            .fan_out    (fan_out[i]),
            .en         (ch_mask[i]),
            .depth      (depth_c[i]),
            .viol       (viol_c[i])
        );
    end

    always_comb begin
        next_state = (state == ACCUM && accept && last) ? DRAIN :
                     (state == DRAIN)                   ? REPORT :
                     (state == REPORT && out_ready)     ? ACCUM : state;
    end

    // Ascending scan with strict > keeps the earlier sample and the lower channel on ties.
    always_comb begin
        max_nx = max_depth;
        ch_nx = max_ch;
        for (int i = 0; i < N_CH; i++) begin
            if (s1_mask[i] && s1_depth[i] > max_nx) begin
                max_nx = s1_depth[i];
                ch_nx = CH_W'(i);
            end
        end
        ff_sum = 64'(ff_total) + 64'(s1_ff) * 64'(popcount(64'(s1_mask)));
        ff_nx = (|ff_sum[63:FF_W]) ? '1 : ff_sum[FF_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            cnt <= '0;
            s1_valid <= 1'b0;
            s1_mask <= '0;
            s1_ff <= '0;
            max_depth <= '0;
            max_ch <= '0;
            ff_total <= '0;
        end else begin
            state <= next_state;
            s1_valid <= accept;
            if (accept) begin
                s1_mask <= ch_mask;
                s1_ff <= num_ff;
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (clear) begin
                cnt <= '0;
                max_depth <= '0;
                max_ch <= '0;
                ff_total <= '0;
            end else if (s1_valid) begin
                max_depth <= max_nx;
                max_ch <= ch_nx;
                ff_total <= ff_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) s1_depth <= depth_c;
    end

`ifdef LDP_VIOL_EN
    logic [N_CH-1:0] s1_viol;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_viol <= '0;
            viol_mask <= '0;
        end else begin
            if (accept) s1_viol <= viol_c;
            if (clear) viol_mask <= '0;
            else if (s1_valid) viol_mask <= viol_mask | s1_viol;
        end
    end
`else
    logic [N_CH-1:0] unused_viol;
    assign unused_viol = viol_c;
    assign viol_mask = '0;
`endif
endmodule

// File: tb/tb_logic_depth_profiler.sv
// tb_logic_depth_profiler: directed table windows plus random windows against a window-level model.
module tb_logic_depth_profiler;
    localparam int N_CH = 8;
    localparam int W = 8;
    localparam int WIN = 4;
    localparam int FF_W = 16;

`ifdef LDP_VIOL_EN
    localparam bit VIOL_ON = 1'b1;
    localparam logic [7:0] VIOL_EXP = 8'h08;
`else
    localparam bit VIOL_ON = 1'b0;
    localparam logic [7:0] VIOL_EXP = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [7:0] ch_mask = '0, fan_in = '0, fan_out = '0;
    logic [7:0] gate_count = '0, path_length = '0, num_ff = '0, depth_limit = '0;
    logic [7:0] max_depth;
    logic [2:0] max_ch;
    logic [15:0] ff_total;
    logic [7:0] viol_mask;

    int n_pass = 0;
    int n_total = 0;

    typedef struct { logic [7:0] mask, fi, fo, gate, path, nff, lim; } sample_t;
    typedef struct { logic [7:0] md; logic [2:0] mc; logic [15:0] ff; logic [7:0] viol; } result_t;
    typedef struct { string name; sample_t s[4]; result_t e; } vec_t;

    vec_t vecs[5];
    sample_t cur[4];

    logic_depth_profiler #(.N_CH(N_CH), .W(W), .WIN(WIN), .FF_W(FF_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ch_mask(ch_mask), .fan_in(fan_in), .fan_out(fan_out),
        .gate_count(gate_count), .path_length(path_length), .num_ff(num_ff),
        .depth_limit(depth_limit), .out_valid(out_valid), .out_ready(out_ready),
        .max_depth(max_depth), .max_ch(max_ch), .ff_total(ff_total), .viol_mask(viol_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endfunction

    function automatic sample_t mk(logic [7:0] mask, logic [7:0] fi, logic [7:0] fo,
                                   logic [7:0] gate, logic [7:0] path, logic [7:0] nff, logic [7:0] lim);
        sample_t s;
        s.mask = mask; s.fi = fi; s.fo = fo; s.gate = gate; s.path = path; s.nff = nff; s.lim = lim;
        return s;
    endfunction

    function automatic result_t model();
        result_t r;
        int tot, d;
        r = '{8'd0, 3'd0, 16'd0, 8'd0};
        tot = 0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                if (cur[k].mask[c]) begin
                    d = int'(cur[k].gate) + int'(cur[k].path) + int'(cur[k].fi[c]) + int'(cur[k].fo[c]) - int'(cur[k].nff);
                    d = (d < 0) ? 0 : (d > 255) ? 255 : d;
                    if (d > int'(r.md)) begin
                        r.md = d[7:0];
                        r.mc = c[2:0];
                    end
                    if (VIOL_ON && d > int'(cur[k].lim)) r.viol[c] = 1'b1;
                end
            end
            tot += int'(cur[k].nff) * $countones(cur[k].mask);
        end
        r.ff = (tot > 65535) ? 16'hFFFF : tot[15:0];
        return r;
    endfunction

    task automatic send(input sample_t s);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready timeout", {31'd0, in_ready}, 1);
        ch_mask = s.mask; fan_in = s.fi; fan_out = s.fo;
        gate_count = s.gate; path_length = s.path; num_ff = s.nff; depth_limit = s.lim;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_window(input string nm, input result_t e, input bit bp);
        int n;
        for (int k = 0; k < 4; k++) send(cur[k]);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 2);
        chk({nm, " max_depth"}, {24'd0, max_depth}, {24'd0, e.md});
        chk({nm, " max_ch"}, {29'd0, max_ch}, {29'd0, e.mc});
        chk({nm, " ff_total"}, {16'd0, ff_total}, {16'd0, e.ff});
        chk({nm, " viol_mask"}, {24'd0, viol_mask}, {24'd0, e.viol});
        if (bp) begin
            ch_mask = 8'hFF; gate_count = 8'hFF; path_length = 8'hFF; num_ff = 8'h01;
            in_valid = 1'b1;
            for (int k = 0; k < 10; k++) @(negedge clk);
            chk({nm, " bp out_valid"}, {31'd0, out_valid}, 1);
            chk({nm, " bp in_ready"}, {31'd0, in_ready}, 0);
            chk({nm, " bp max_depth"}, {24'd0, max_depth}, {24'd0, e.md});
            chk({nm, " bp max_ch"}, {29'd0, max_ch}, {29'd0, e.mc});
            chk({nm, " bp ff_total"}, {16'd0, ff_total}, {16'd0, e.ff});
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " ack in_ready"}, {31'd0, in_ready}, 1);
        chk({nm, " ack out_valid"}, {31'd0, out_valid}, 0);
        chk({nm, " ack max_depth"}, {24'd0, max_depth}, 0);
        chk({nm, " ack ff_total"}, {16'd0, ff_total}, 0);
        chk({nm, " ack viol_mask"}, {24'd0, viol_mask}, 0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            vecs[0].s[k] = mk(8'h01, 8'h01, 8'h01, 8'd10, 8'd20, 8'd2, 8'd255);
            vecs[1].s[k] = mk(8'h80, 8'h00, 8'h00, 8'd200, 8'd100, 8'd0, 8'd255);
            vecs[2].s[k] = mk(8'hFF, 8'h00, 8'h00, 8'd0, 8'd0, 8'd5, 8'd0);
            vecs[3].s[k] = mk(8'h08, 8'h08, 8'h08, 8'd10, 8'd20, 8'd2, 8'd25);
        end
        vecs[4].s[0] = mk(8'h06, 8'h00, 8'h00, 8'd50, 8'd0, 8'd0, 8'd255);
        vecs[4].s[1] = mk(8'h80, 8'h00, 8'h00, 8'd50, 8'd0, 8'd0, 8'd255);
        vecs[4].s[2] = mk(8'h00, 8'h00, 8'h00, 8'd250, 8'd0, 8'd0, 8'd255);
        vecs[4].s[3] = mk(8'h10, 8'h00, 8'h00, 8'd40, 8'd0, 8'd0, 8'd255);
        vecs[0].name = "basic";     vecs[0].e = '{8'd30, 3'd0, 16'd8, 8'h00};
        vecs[1].name = "overflow";  vecs[1].e = '{8'd255, 3'd7, 16'd0, 8'h00};
        vecs[2].name = "underflow"; vecs[2].e = '{8'd0, 3'd0, 16'd160, 8'h00};
        vecs[3].name = "violation"; vecs[3].e = '{8'd30, 3'd3, 16'd8, VIOL_EXP};
        vecs[4].name = "ties";      vecs[4].e = '{8'd50, 3'd1, 16'd0, 8'h00};

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 1);
        chk("reset out_valid", {31'd0, out_valid}, 0);
        chk("reset max_depth", {24'd0, max_depth}, 0);
        chk("reset max_ch", {29'd0, max_ch}, 0);
        chk("reset ff_total", {16'd0, ff_total}, 0);
        chk("reset viol_mask", {24'd0, viol_mask}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            cur = vecs[v].s;
            run_window(vecs[v].name, vecs[v].e, v == 0);
        end

        send(mk(8'hFF, 8'hFF, 8'h00, 8'd200, 8'd50, 8'd0, 8'd0));
        send(mk(8'hFF, 8'h00, 8'hFF, 8'd200, 8'd50, 8'd9, 8'd0));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst in_ready", {31'd0, in_ready}, 1);
        chk("midrst out_valid", {31'd0, out_valid}, 0);
        chk("midrst ff_total", {16'd0, ff_total}, 0);
        rst = 1'b0;
        @(negedge clk);
        cur = vecs[0].s;
        run_window("after_rst", vecs[0].e, 1'b0);

        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 4; k++) begin
                cur[k] = mk(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                            8'($urandom), 8'($urandom));
            end
            run_window("random", model(), r % 6 == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
